// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-select and hazard-stall unit for a 5-stage
// pipeline (IF/ID/EXE/MEM/WB).
//
// A private shadow copy of the EXE/MEM/WB tags is kept. EXE operand forward
// selects come only from that shadow state. The ID stall comes from the ID
// inputs compared against the shadow EXE/MEM entries.
//
// Optional feature macro: FWD_PERF_EN
//   When defined, saturating stall and forward cycle counters are built.
//   When undefined, both counters are tied to zero and no flops are built.
//
// Only the EXE entry keeps its source indices.
// MEM and WB keep only the fields that later comparisons read: valid,
// wb_en and dest.
module fwd_hazard_unit #(
    parameter int NUM_SRC = 3,
    parameter int REG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_forward_en,
    input  logic                     i_flush,
    input  logic                     i_id_valid,
    input  logic [NUM_SRC*REG_W-1:0] i_id_src,
    input  logic [NUM_SRC-1:0]       i_id_src_used,
    input  logic [REG_W-1:0]         i_id_dest,
    input  logic                     i_id_wb_en,
    input  logic                     i_id_mem_read,
    output logic                     o_stall,
    output logic [2*NUM_SRC-1:0]     o_sel_src,
    output logic [CNT_W-1:0]         o_stall_cnt,
    output logic [CNT_W-1:0]         o_fwd_cnt
);

    // Shadow EXE stage
    logic                     r_exe_valid;
    logic [NUM_SRC*REG_W-1:0] r_exe_src;
    logic [NUM_SRC-1:0]       r_exe_src_used;
    logic [REG_W-1:0]         r_exe_dest;
    logic                     r_exe_wb_en;
    logic                     r_exe_mem_read;

    // Shadow MEM and WB stages
    logic                     r_mem_valid;
    logic [REG_W-1:0]         r_mem_dest;
    logic                     r_mem_wb_en;
    logic                     r_wb_valid;
    logic [REG_W-1:0]         r_wb_dest;
    logic                     r_wb_wb_en;

    // Per-operand hazard flags for ID against EXE and against MEM
    logic [NUM_SRC-1:0]       w_hz_exe;
    logic [NUM_SRC-1:0]       w_hz_mem;
    logic                     w_hz;
    logic                     w_stall;
    logic                     w_issue;

    // A live entry that writes the register file
    logic                     w_exe_writer;
    logic                     w_mem_writer;
    logic                     w_wb_writer;

    assign w_exe_writer = r_exe_valid & r_exe_wb_en;
    assign w_mem_writer = r_mem_valid & r_mem_wb_en;
    assign w_wb_writer  = r_wb_valid & r_wb_wb_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_W-1:0] w_id_src_k;
            logic [REG_W-1:0] w_exe_src_k;
            logic             w_id_reads;
            logic             w_exe_reads;

            assign w_id_src_k  = i_id_src[gi*REG_W +: REG_W];
            assign w_exe_src_k = r_exe_src[gi*REG_W +: REG_W];
            assign w_id_reads  = i_id_valid & i_id_src_used[gi];
            assign w_exe_reads = i_forward_en & r_exe_valid & r_exe_src_used[gi];

            assign w_hz_exe[gi] = w_id_reads & w_exe_writer & (r_exe_dest == w_id_src_k);
            assign w_hz_mem[gi] = w_id_reads & w_mem_writer & (r_mem_dest == w_id_src_k);

            // Forward select: the younger MEM result takes priority over WB
            always_comb begin
                o_sel_src[2*gi +: 2] = 2'b00;
                if (w_exe_reads) begin
                    if (w_mem_writer && (r_mem_dest == w_exe_src_k))
                        o_sel_src[2*gi +: 2] = 2'b01;
                    else if (w_wb_writer && (r_wb_dest == w_exe_src_k))
                        o_sel_src[2*gi +: 2] = 2'b10;
                end
            end
        end
    endgenerate

    // Forwarding mode stalls only on load-use.
    // Stall-only mode waits until the writer reaches WB, because the
    // register file is written before the ID read in that stage.
    assign w_hz    = i_forward_en ? ((|w_hz_exe) & r_exe_mem_read)
                                  : ((|w_hz_exe) | (|w_hz_mem));
    assign w_stall = w_hz & ~i_flush;
    assign o_stall = w_stall;
    assign w_issue = ~i_flush & ~w_stall;

    // EXE takes the ID instruction, or a bubble on a flush or a stall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exe_valid    <= 1'b0;
            r_exe_src      <= '0;
            r_exe_src_used <= '0;
            r_exe_dest     <= '0;
            r_exe_wb_en    <= 1'b0;
            r_exe_mem_read <= 1'b0;
        end else begin
            r_exe_src      <= i_id_src;
            r_exe_src_used <= i_id_src_used;
            r_exe_dest     <= i_id_dest;
            r_exe_valid    <= w_issue & i_id_valid;
            r_exe_wb_en    <= w_issue & i_id_wb_en;
            r_exe_mem_read <= w_issue & i_id_mem_read;
        end
    end

    // The back end always advances: EXE moves to MEM, and MEM moves to WB
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_valid <= 1'b0;
            r_mem_dest  <= '0;
            r_mem_wb_en <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_wb_en  <= 1'b0;
        end else begin
            r_mem_valid <= r_exe_valid;
            r_mem_dest  <= r_exe_dest;
            r_mem_wb_en <= r_exe_wb_en;
            r_wb_valid  <= r_mem_valid;
            r_wb_dest   <= r_mem_dest;
            r_wb_wb_en  <= r_mem_wb_en;
        end
    end

`ifdef FWD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;
    logic             w_any_fwd;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign w_any_fwd = |o_sel_src;

    // Saturating counts of stalled cycles and forwarding cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_any_fwd && (r_fwd_cnt != '1))
                r_fwd_cnt <= r_fwd_cnt + CNT_ONE;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_fwd_cnt   = r_fwd_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_fwd_cnt   = '0;
`endif

endmodule
